// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 clock-display writer:
// FSM/byte-phase enums, LCD command bytes, timing lengths and line-1 ASCII glyphs.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_FUNC_SET,
        ST_DISP_ON,
        ST_ENTRY_MODE,
        ST_CLEAR,
        ST_WAIT_CLR,
        ST_LINE1,
        ST_LINE2
    } lcdState_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } bytePhase_t;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_LINE1_ADDR = 8'h80;
    localparam logic [7:0] CMD_LINE2_ADDR = 8'hC0;

    localparam logic [4:0] DELAY_CYCLES    = 5'd20;
    localparam logic [4:0] WAIT_CLR_CYCLES = 5'd2;
    localparam logic [4:0] LINE_BYTES      = 5'd16;

    localparam logic [7:0] ASC_T     = 8'h54;
    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_M     = 8'h4D;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_DASH  = 8'h2D;

endpackage

// File: rtl/lcd_clock_display_bin2ascii2.sv
// Combinational 7-bit binary to two ASCII digits; values of 100 or more show "--".
module bin2ascii2
    import lcd_pkg::*;
(
    input  logic [6:0] i_value,
    output logic [7:0] o_tens,
    output logic [7:0] o_units
);

    logic [6:0] w_tens;
    logic [6:0] w_units;

    always_comb begin
        w_tens  = i_value / 7'd10;
        w_units = i_value % 7'd10;
        if (i_value >= 7'd100) begin
            o_tens  = ASC_DASH;
            o_units = ASC_DASH;
        end else begin
            o_tens  = ASC_ZERO + {1'b0, w_tens};
            o_units = ASC_ZERO + {1'b0, w_units};
        end
    end

endmodule

// File: rtl/lcd_clock_display.sv
// 16x2 character-LCD writer: power-on init, then endless refresh of the time line and LINE2_DATA.
// Define LCD_24H_EN for "TIME    HH:MM:SS" (24-hour) instead of the AM/PM line.
module lcd_clock_display
    import lcd_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MERIDIEM,
    input  logic [6:0]   HOUR,
    input  logic [6:0]   MIN,
    input  logic [6:0]   SEC,
    input  logic [127:0] LINE2_DATA,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [7:0]   LCD_DATA,
    output logic         FRAME_DONE
);

    lcdState_t    r_state;
    bytePhase_t   r_phase;
    logic [4:0]   r_cnt;
    logic [6:0]   r_hour;
    logic [6:0]   r_min;
    logic [6:0]   r_sec;
    logic         r_mer;
    logic [127:0] r_line2;

    logic [6:0] w_hourVal;
    logic [7:0] w_hourTens, w_hourUnits;
    logic [7:0] w_minTens, w_minUnits;
    logic [7:0] w_secTens, w_secUnits;
    logic [7:0] w_merChar0, w_merChar1;
    logic [7:0] w_line1Char;
    logic [7:0] w_line2Char;

    bin2ascii2 u_hourDigits (.i_value(w_hourVal), .o_tens(w_hourTens), .o_units(w_hourUnits));
    bin2ascii2 u_minDigits  (.i_value(r_min),     .o_tens(w_minTens),  .o_units(w_minUnits));
    bin2ascii2 u_secDigits  (.i_value(r_sec),     .o_tens(w_secTens),  .o_units(w_secUnits));

    assign LCD_RW = 1'b0;

    // Raw hours of 100+ bypass the PM offset so they still render as "--".
    always_comb begin
`ifdef LCD_24H_EN
        w_hourVal  = (r_hour >= 7'd100) ? r_hour : r_hour + (r_mer ? 7'd12 : 7'd0);
        w_merChar0 = ASC_SPACE;
        w_merChar1 = ASC_SPACE;
`else
        w_hourVal  = r_hour;
        w_merChar0 = r_mer ? ASC_P : ASC_A;
        w_merChar1 = ASC_M;
`endif
    end

    always_comb begin
        w_line1Char = ASC_SPACE;
        case (r_cnt[3:0])
            4'd0:    w_line1Char = ASC_T;
            4'd1:    w_line1Char = ASC_I;
            4'd2:    w_line1Char = ASC_M;
            4'd3:    w_line1Char = ASC_E;
            4'd5:    w_line1Char = w_merChar0;
            4'd6:    w_line1Char = w_merChar1;
            4'd8:    w_line1Char = w_hourTens;
            4'd9:    w_line1Char = w_hourUnits;
            4'd10:   w_line1Char = ASC_COLON;
            4'd11:   w_line1Char = w_minTens;
            4'd12:   w_line1Char = w_minUnits;
            4'd13:   w_line1Char = ASC_COLON;
            4'd14:   w_line1Char = w_secTens;
            4'd15:   w_line1Char = w_secUnits;
            default: w_line1Char = ASC_SPACE;
        endcase
        w_line2Char = r_line2[{~r_cnt[3:0], 3'b000} +: 8];
    end

    // r_cnt is the delay counter in DELAY/WAIT_CLR and the byte index (0 = address) in LINE1/LINE2.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_DELAY;
            r_phase    <= PH_SETUP;
            r_cnt      <= 5'd0;
            r_hour     <= 7'd0;
            r_min      <= 7'd0;
            r_sec      <= 7'd0;
            r_mer      <= 1'b0;
            r_line2    <= '0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (r_state)
                ST_DELAY: begin
                    if (r_cnt == DELAY_CYCLES - 5'd1) begin
                        r_state  <= ST_FUNC_SET;
                        r_phase  <= PH_SETUP;
                        r_cnt    <= 5'd0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= CMD_FUNC_SET;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_WAIT_CLR: begin
                    if (r_cnt == WAIT_CLR_CYCLES - 5'd1) begin
                        r_state  <= ST_LINE1;
                        r_phase  <= PH_SETUP;
                        r_cnt    <= 5'd0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= CMD_LINE1_ADDR;
                        r_hour   <= HOUR;
                        r_min    <= MIN;
                        r_sec    <= SEC;
                        r_mer    <= MERIDIEM;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    case (r_phase)
                        PH_SETUP: begin
                            r_phase <= PH_PULSE;
                            LCD_E   <= 1'b1;
                        end
                        PH_PULSE: begin
                            r_phase <= PH_HOLD;
                            LCD_E   <= 1'b0;
                            if (r_state == ST_LINE2 && r_cnt == LINE_BYTES) begin
                                FRAME_DONE <= 1'b1;
                            end
                        end
                        default: begin
                            r_phase <= PH_SETUP;
                            case (r_state)
                                ST_FUNC_SET: begin
                                    r_state  <= ST_DISP_ON;
                                    LCD_DATA <= CMD_DISP_ON;
                                end
                                ST_DISP_ON: begin
                                    r_state  <= ST_ENTRY_MODE;
                                    LCD_DATA <= CMD_ENTRY_MODE;
                                end
                                ST_ENTRY_MODE: begin
                                    r_state  <= ST_CLEAR;
                                    LCD_DATA <= CMD_CLEAR;
                                end
                                ST_CLEAR: begin
                                    r_state <= ST_WAIT_CLR;
                                    r_cnt   <= 5'd0;
                                end
                                ST_LINE1: begin
                                    if (r_cnt == LINE_BYTES) begin
                                        r_state  <= ST_LINE2;
                                        r_cnt    <= 5'd0;
                                        LCD_RS   <= 1'b0;
                                        LCD_DATA <= CMD_LINE2_ADDR;
                                        r_line2  <= LINE2_DATA;
                                    end else begin
                                        r_cnt    <= r_cnt + 5'd1;
                                        LCD_RS   <= 1'b1;
                                        LCD_DATA <= w_line1Char;
                                    end
                                end
                                ST_LINE2: begin
                                    if (r_cnt == LINE_BYTES) begin
                                        r_state  <= ST_LINE1;
                                        r_cnt    <= 5'd0;
                                        LCD_RS   <= 1'b0;
                                        LCD_DATA <= CMD_LINE1_ADDR;
                                        r_hour   <= HOUR;
                                        r_min    <= MIN;
                                        r_sec    <= SEC;
                                        r_mer    <= MERIDIEM;
                                    end else begin
                                        r_cnt    <= r_cnt + 5'd1;
                                        LCD_RS   <= 1'b1;
                                        LCD_DATA <= w_line2Char;
                                    end
                                end
                                default: r_state <= ST_DELAY;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
